forward: RTL and testbench



---
 rtl/forward.sv | 74 +++++++
 tb/tb_forward.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/forward.sv
// -----------------------------------------------------------------------------
// forward -- forward/mov unit of the 8-bit processor ALU.
//
// The operand data2 is presented unchanged on result with zero latency; the
// forward path has no clock or reset dependence. Alongside it, a clocked
// observation path registers the operand, flags when the live operand differs
// from the registered copy, and keeps a saturating count of the edges on
// which that flag was high. The observation path never feeds result.
//
// Optional feature macro: FORWARD_ZERO_FLAG_EN adds the combinational zero
// output (high when result == 0).
//
// Parameters:
//   WIDTH        operand / result width
//   CNT_WIDTH    change counter width
//
// Ports:
//   clk           in   clock, observation path updates on rising edge
//   rst_n         in   asynchronous active-low reset (observation path only)
//   data2         in   operand to forward
//   result        out  forwarded operand, combinational
//   data2_q       out  registered copy of data2
//   changed       out  data2 != data2_q, combinational
//   change_count  out  saturating count of edges with changed high
//   zero          out  result == 0 (only with FORWARD_ZERO_FLAG_EN)
// -----------------------------------------------------------------------------
module forward #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     data2,
    output logic [WIDTH-1:0]     result,
    output logic [WIDTH-1:0]     data2_q,
    output logic                 changed,
`ifdef FORWARD_ZERO_FLAG_EN
    output logic [CNT_WIDTH-1:0] change_count,
    output logic                 zero
`else
    output logic [CNT_WIDTH-1:0] change_count
`endif
);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v)
            return v;
        else
            return v + 1'b1;
    endfunction

    // Forward path: plain wire, so X/Z on data2 reaches result untouched.
    assign result  = data2;

    assign changed = (data2 != data2_q);

`ifdef FORWARD_ZERO_FLAG_EN
    assign zero = (result == '0);
`endif

    // ---- stage p0 -> p1: registered operand and change counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data2_q      <= '0;
            change_count <= '0;
        end else begin
            data2_q <= data2;
            if (changed)
                change_count <= sat_inc(change_count);
        end
    end

endmodule

// File: tb/tb_forward.sv
// -----------------------------------------------------------------------------
// tb_forward -- self-checking bench for forward.
// Expected observation-path state is produced by a small reference model at
// stimulus time, pushed to a scoreboard queue and popped after the clock edge.
// -----------------------------------------------------------------------------
module tb_forward;

    localparam int WIDTH     = 8;
    localparam int CNT_WIDTH = 8;

    logic                 clk;
    logic                 clk_en;
    logic                 rst_n;
    logic [WIDTH-1:0]     data2;
    logic [WIDTH-1:0]     result;
    logic [WIDTH-1:0]     data2_q;
    logic                 changed;
    logic [CNT_WIDTH-1:0] change_count;
`ifdef FORWARD_ZERO_FLAG_EN
    logic                 zero;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WIDTH-1:0]     q;
        logic [CNT_WIDTH-1:0] cnt;
        logic                 chg;
        logic [WIDTH-1:0]     res;
    } exp_t;

    exp_t sb[$];

    // reference model of the observation path
    logic [WIDTH-1:0]     m_q;
    logic [CNT_WIDTH-1:0] m_cnt;

    forward #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data2        (data2),
        .result       (result),
        .data2_q      (data2_q),
        .changed      (changed),
`ifdef FORWARD_ZERO_FLAG_EN
        .change_count (change_count),
        .zero         (zero)
`else
        .change_count (change_count)
`endif
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Drive one operand value, predict the post-edge state, queue it, and
    // advance to just after the next rising edge.
    task automatic drive_edge(input logic [WIDTH-1:0] v);
        exp_t e;
        data2 = v;
        if (v != m_q && m_cnt != {CNT_WIDTH{1'b1}})
            m_cnt = m_cnt + 1'b1;
        m_q   = v;
        e.q   = m_q;
        e.cnt = m_cnt;
        e.chg = 1'b0;   // data2 is held across the edge, so it matches data2_q
        e.res = v;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_forward;
        logic [WIDTH-1:0] vals [3];
        vals[0] = 8'd25; vals[1] = 8'd1; vals[2] = 8'd34;
        for (int i = 0; i < 3; i++) begin
            data2 = vals[i];
            #1;
            checks++;
            if (result !== vals[i]) begin
                errors++;
                $display("FAIL fwd_noclk[%0d] result=%0d expected=%0d", i, result, vals[i]);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        data2 = 8'd34;
        m_q   = '0;
        m_cnt = '0;
        #1;
        checks++;
        if (data2_q !== 8'd0) begin
            errors++; $display("FAIL rst_data2_q got=%0d expected=0", data2_q);
        end
        checks++;
        if (change_count !== 8'd0) begin
            errors++; $display("FAIL rst_count got=%0d expected=0", change_count);
        end
        checks++;
        if (changed !== 1'b1) begin
            errors++; $display("FAIL rst_changed got=%b expected=1", changed);
        end
        checks++;
        if (result !== 8'd34) begin
            errors++; $display("FAIL rst_result got=%0d expected=34", result);
        end
    endtask

    task automatic test_registered;
        exp_t e;
        clk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_edge(8'd7);
            e = sb.pop_front();
            checks++;
            if (data2_q !== e.q || change_count !== e.cnt || changed !== e.chg || result !== e.res) begin
                errors++;
                $display("FAIL reg_path[%0d] q=%0d cnt=%0d chg=%b res=%0d expected q=%0d cnt=%0d chg=%b res=%0d",
                         i, data2_q, change_count, changed, result, e.q, e.cnt, e.chg, e.res);
            end
        end
        checks++;
        if (change_count !== 8'd1) begin
            errors++; $display("FAIL reg_count_final got=%0d expected=1", change_count);
        end
    endtask

    task automatic test_saturation;
        exp_t e;
        for (int i = 0; i < 300; i++) begin
            drive_edge((i % 2 == 0) ? 8'h55 : 8'hAA);
            e = sb.pop_front();
            checks++;
            if (data2_q !== e.q || change_count !== e.cnt) begin
                errors++;
                $display("FAIL sat[%0d] q=%h cnt=%0d expected q=%h cnt=%0d",
                         i, data2_q, change_count, e.q, e.cnt);
            end
        end
        checks++;
        if (change_count !== 8'd255) begin
            errors++; $display("FAIL sat_hold got=%0d expected=255", change_count);
        end
    endtask

    task automatic test_mid_reset;
        exp_t e;
        // clear, then build the count up to exactly 10
        rst_n = 1'b0;
        m_q   = '0;
        m_cnt = '0;
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive_edge(WIDTH'(i * 3));
            e = sb.pop_front();
            checks++;
            if (change_count !== e.cnt || data2_q !== e.q) begin
                errors++;
                $display("FAIL mid_build[%0d] cnt=%0d q=%0d expected cnt=%0d q=%0d",
                         i, change_count, data2_q, e.cnt, e.q);
            end
        end
        checks++;
        if (change_count !== 8'd10) begin
            errors++; $display("FAIL mid_pre got=%0d expected=10", change_count);
        end
        // pulse reset well away from any edge
        #1;
        rst_n = 1'b0;
        m_q   = '0;
        m_cnt = '0;
        #1;
        checks++;
        if (change_count !== 8'd0 || data2_q !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset cnt=%0d q=%0d expected cnt=0 q=0", change_count, data2_q);
        end
        checks++;
        if (changed !== 1'b1) begin
            errors++; $display("FAIL mid_reset_changed got=%b expected=1", changed);
        end
        rst_n = 1'b1;
        // counting resumes on the first edge after release
        drive_edge(8'd30);
        e = sb.pop_front();
        checks++;
        if (change_count !== e.cnt || data2_q !== e.q) begin
            errors++;
            $display("FAIL mid_resume cnt=%0d q=%0d expected cnt=%0d q=%0d",
                     change_count, data2_q, e.cnt, e.q);
        end
    endtask

`ifdef FORWARD_ZERO_FLAG_EN
    task automatic test_zero;
        data2 = 8'd0;
        #1;
        checks++;
        if (zero !== 1'b1) begin
            errors++; $display("FAIL zero_on got=%b expected=1", zero);
        end
        data2 = 8'd1;
        #1;
        checks++;
        if (zero !== 1'b0) begin
            errors++; $display("FAIL zero_off got=%b expected=0", zero);
        end
    endtask
`endif

    initial begin
        clk_en = 1'b0;
        rst_n  = 1'b0;
        data2  = '0;
        m_q    = '0;
        m_cnt  = '0;
        test_forward();
        test_reset();
        test_registered();
        test_saturation();
        test_mid_reset();
`ifdef FORWARD_ZERO_FLAG_EN
        test_zero();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
